// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : alu_multicycle
// Description : Handshaked ALU. Single-cycle operations (add, sub, logic,
//               compares, shifts) finish one edge after accept; mul runs an
//               iterative shift-add, one multiplier bit per cycle.
// Ports       : clk, rst          - clock, async active-high reset
//               in_valid/in_ready - request handshake (ready only in IDLE)
//               ALUctrl           - 4-bit opcode
//               ALUop1/ALUop2     - operands (DATA_WIDTH)
//               out_valid/out_ready - result handshake (valid only in DONE)
//               ALUout            - registered result
//               eq                - registered ALUop1 == ALUop2 of the request
//               zero              - registered ALUout == 0
// Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  // Legal values: powers of two from 8 to 64.
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  eq,
  output logic                  zero
);

  localparam int              CNT_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [3:0] C_OP_ADD  = 4'b0000;
  localparam logic [3:0] C_OP_SUB  = 4'b0001;
  localparam logic [3:0] C_OP_AND  = 4'b0010;
  localparam logic [3:0] C_OP_OR   = 4'b0011;
  localparam logic [3:0] C_OP_SLTU = 4'b0100;
  localparam logic [3:0] C_OP_SLT  = 4'b0101;
  localparam logic [3:0] C_OP_XOR  = 4'b0110;
  localparam logic [3:0] C_OP_SLL  = 4'b0111;
  localparam logic [3:0] C_OP_SRL  = 4'b1000;
  localparam logic [3:0] C_OP_SRA  = 4'b1001;
  localparam logic [3:0] C_OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   mcand_q;   // multiplicand, shifted left each step
  logic [DATA_WIDTH-1:0]   mplier_q;  // multiplier, shifted right each step
  logic [DATA_WIDTH-1:0]   pp_q;      // partial product
  logic                    eq_pend_q; // eq of the accepted mul, held until DONE
  logic [DATA_WIDTH-1:0]   aluout_q;
  logic                    eq_q;
  logic                    zero_q;

  logic [SHAMT_WIDTH-1:0]  w_shamt;
  logic signed [DATA_WIDTH-1:0] w_sra;
  logic [DATA_WIDTH-1:0]   res_d;
  logic [DATA_WIDTH-1:0]   pp_d;
  logic                    w_eq;

  assign w_shamt = ALUop2[SHAMT_WIDTH-1:0];
  assign w_sra   = $signed(ALUop1) >>> w_shamt;
  assign w_eq    = (ALUop1 == ALUop2);

  // Low DATA_WIDTH bits of the product only, so the accumulator never widens.
  assign pp_d = pp_q + (mcand_q & {DATA_WIDTH{mplier_q[0]}});

  always_comb begin
    res_d = '0;
    case (ALUctrl)
      C_OP_ADD:  res_d = ALUop1 + ALUop2;
      C_OP_SUB:  res_d = ALUop1 - ALUop2;
      C_OP_AND:  res_d = ALUop1 & ALUop2;
      C_OP_OR:   res_d = ALUop1 | ALUop2;
      C_OP_SLTU: res_d = {{(DATA_WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
      C_OP_SLT:  res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
      C_OP_XOR:  res_d = ALUop1 ^ ALUop2;
      C_OP_SLL:  res_d = ALUop1 << w_shamt;
      C_OP_SRL:  res_d = ALUop1 >> w_shamt;
      C_OP_SRA:  res_d = w_sra;
      default:   res_d = '0;  // mul handled by the FSM; 1011..1111 yield 0
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      pp_q      <= '0;
      eq_pend_q <= 1'b0;
      aluout_q  <= '0;
      eq_q      <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (ALUctrl == C_OP_MUL) begin
              mcand_q   <= ALUop1;
              mplier_q  <= ALUop2;
              pp_q      <= '0;
              cnt_q     <= '0;
              eq_pend_q <= w_eq;
              state_q   <= S_MUL;
            end else begin
              aluout_q <= res_d;
              eq_q     <= w_eq;
              zero_q   <= (res_d == '0);
              state_q  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          pp_q     <= pp_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == C_CNT_LAST) begin
            // Last multiplier bit: publish the finished product.
            aluout_q <= pp_d;
            eq_q     <= eq_pend_q;
            zero_q   <= (pp_d == '0);
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign ALUout    = aluout_q;
  assign eq        = eq_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_multicycle
// Description : Self-checking bench for alu_multicycle (DATA_WIDTH = 32).
//               Directed cases plus randomized operations compared against a
//               behavioural arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUctrl;
  logic [31:0] ALUop1;
  logic [31:0] ALUop2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUout;
  logic        eq;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUctrl   (ALUctrl),
    .ALUop1    (ALUop1),
    .ALUop2    (ALUop2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .eq        (eq),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Behavioural reference: plain arithmetic on the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [63:0] prod;
    logic [31:0] fill;
    sh   = b % 32;
    prod = 64'(a) * 64'(b);
    fill = 32'hFFFF_FFFF;
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6:  return a ^ b;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return (a >> sh) | (a[31] ? ~(fill >> sh) : 32'd0);
      4'd10: return prod[31:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: drive, accept, measure latency, check result, optional
  // backpressure for `stall` cycles, then release and confirm return to IDLE.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int stall);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    exp     = ref_alu(c, a, b);
    exp_lat = (c == 4'd10) ? 33 : 1;
    @(negedge clk);
    ALUctrl   = c;
    ALUop1    = a;
    ALUop2    = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    chk(32'(in_ready), 32'd1, "in_ready_idle");
    @(posedge clk); #1;
    // Scramble inputs after accept; they must not affect the result.
    in_valid = 1'b0;
    ALUctrl  = 4'($urandom);
    ALUop1   = $urandom;
    ALUop2   = $urandom;
    lat = 1;
    while (!out_valid && lat < 60) begin
      chk(32'(in_ready), 32'd0, "in_ready_busy");
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end
    chk(32'(lat), 32'(exp_lat), "latency");
    chk(ALUout, exp, "result");
    chk(32'(eq), 32'(a == b), "eq");
    chk(32'(zero), 32'(exp == 32'd0), "zero");
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      ALUop1   = $urandom;
      ALUop2   = $urandom;
      @(posedge clk); #1;
      chk(32'(out_valid), 32'd1, "stall_valid");
      chk(ALUout, exp, "stall_result");
      chk(32'(in_ready), 32'd0, "stall_in_ready");
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk(32'(out_valid), 32'd0, "release_valid");
    chk(32'(in_ready), 32'd1, "release_idle");
    chk(ALUout, exp, "idle_hold");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ALUctrl   = 4'd0;
    ALUop1    = 32'd0;
    ALUop2    = 32'd0;
    #1;
    chk(ALUout, 32'd0, "reset_aluout");
    chk(32'(out_valid), 32'd0, "reset_out_valid");
    chk(32'(in_ready), 32'd1, "reset_in_ready");
    chk(32'(zero), 32'd0, "reset_zero");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(4'd0, 32'd5, 32'd7, 0);
    run_op(4'd1, 32'd3, 32'd5, 0);
    run_op(4'd1, 32'd9, 32'd9, 0);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd9, 32'h8000_0000, 32'h0000_0024, 0);
    run_op(4'd10, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(4'd10, 32'd123, 32'd456, 0);
    run_op(4'd0, 32'd1, 32'd1, 10);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      run_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 3));
    end

    // Reset in the middle of a multiply
    run_op(4'd0, 32'd5, 32'd7, 0);
    @(negedge clk);
    ALUctrl  = 4'd10;
    ALUop1   = 32'd77;
    ALUop2   = 32'd99;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk(32'(out_valid), 32'd0, "mid_mul_valid");
    rst = 1'b1;
    #1;
    chk(ALUout, 32'd0, "async_rst_aluout");
    chk(32'(eq), 32'd0, "async_rst_eq");
    chk(32'(zero), 32'd0, "async_rst_zero");
    chk(32'(out_valid), 32'd0, "async_rst_valid");
    chk(32'(in_ready), 32'd1, "async_rst_ready");
    ALUctrl  = 4'd0;
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk(32'(out_valid), 32'd0, "rst_no_accept");
      chk(ALUout, 32'd0, "rst_hold_zero");
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      chk(32'(out_valid), 32'd0, "discarded_no_valid");
    end
    run_op(4'd0, 32'd2, 32'd2, 0);
    run_op(4'd15, 32'd12, 32'd34, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
